// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states
// and the request legality/alignment helpers used at accept time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;

  // Stores only know B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    return we ? ((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W))
              : ((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU));
  endfunction

  // Size is encoded in funct3[1:0]; bytes can never be misaligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return (f3[1:0] == 2'b01) ? off[0] :
           (f3[1:0] == 2'b10) ? (off != 2'b00) : 1'b0;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between the 32-bit pipeline view and the word RAM:
// byte enables and replicated write data for stores, lane extraction and
// sign/zero extension for loads. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_off,
  input  logic [XLEN-1:0] st_wdata,
  output logic [BE_W-1:0] st_byteen,
  output logic [XLEN-1:0] st_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: enable only the addressed lanes and copy the operand to every lane.
  always_comb begin
    st_byteen = '0;
    st_data   = st_wdata;
    case (st_funct3)
      F3_B: begin
        st_byteen = 4'b0001 << st_off;
        st_data   = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_byteen = 4'b0011 << {st_off[1], 1'b0};
        st_data   = {2{st_wdata[15:0]}};
      end
      F3_W: st_byteen = 4'b1111;
      default: st_byteen = '0;
    endcase
  end

  // Load side: pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time, forms rs1+imm, drives a
// single RAM access and returns a one-cycle response pulse. Faulting
// requests skip the RAM entirely and respond in the following cycle.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DMEM_SIZE  = 2**15,
  parameter int ADDR_WIDTH = $clog2(DMEM_SIZE >> 2),
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_base,
  input  logic [XLEN-1:0]       req_imm,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_fault,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [BE_W-1:0]       mem_byteen,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic [XLEN-1:0]       mem_rdata
);

  localparam int CNT_W = 3;

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic [XLEN-1:0]  eff;
  logic             fault_now;
  logic [BE_W-1:0]  st_byteen;
  logic [XLEN-1:0]  st_data;
  logic [XLEN-1:0]  ld_data;
  logic             unused_eff_hi;

  assign eff           = req_base + req_imm;
  assign fault_now     = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, eff[1:0]);
  assign unused_eff_hi = ^eff[XLEN-1:ADDR_WIDTH+2];

  lsu_align #(.XLEN(XLEN)) u_align (
    .st_funct3 (req_funct3),
    .st_off    (eff[1:0]),
    .st_wdata  (req_wdata),
    .st_byteen (st_byteen),
    .st_data   (st_data),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_rdata  (mem_rdata),
    .ld_data   (ld_data)
  );

  // Request FSM with registered outputs; RAM strobes and the response pulse
  // default low each cycle and are raised only on the transition that needs them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_data  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_byteen <= '0;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q       <= req_we;
            f3_q       <= req_funct3;
            off_q      <= eff[1:0];
            mem_addr   <= eff[ADDR_WIDTH+1:2];
            mem_byteen <= st_byteen;
            mem_wdata  <= st_data;
            req_ready  <= 1'b0;
            if (fault_now) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_data  <= '0;
            end else begin
              state  <= ISSUE;
              mem_en <= 1'b1;
              mem_we <= req_we;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= '0;
          end else begin
            state <= WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(RD_LAT)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_data  <= ld_data;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit between the execute stage and the data-memory wrapper.
- Accepts one memory request at a time from the pipeline and forms the effective address rs1+imm.
- Generates word address, byte enables and lane-replicated store data for the on-chip RAM port.
- For loads, waits the RAM read latency, then returns lane-extracted, sign/zero-extended data with a one-cycle response pulse.

Parameters:
XLEN, 32, data/address width of pipeline operands
DMEM_SIZE, 2**15, data memory size in bytes
ADDR_WIDTH, $clog2(DMEM_SIZE>>2), RAM word-address width
RD_LAT, 1, RAM read latency in cycles from the enable cycle to valid readdata (legal 1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset
req_valid  in  1  pipeline presents a memory op
req_ready  out  1  LSU can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_funct3  in  3  RISC-V funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
req_base  in  XLEN  rs1 value
req_imm  in  XLEN  sign-extended offset
req_wdata  in  XLEN  rs2 value
resp_valid  out  1  one-cycle completion pulse
resp_data  out  XLEN  load result (0 for stores/faults)
resp_fault  out  1  valid with resp_valid: misaligned or illegal funct3
mem_addr  out  ADDR_WIDTH  RAM word address
mem_en  out  1  RAM clken/chipselect
mem_we  out  1  RAM write
mem_byteen  out  4  RAM byte enables
mem_wdata  out  XLEN  RAM write data
mem_rdata  in  XLEN  RAM readdata

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, so req_ready=1. resp_valid, resp_fault, mem_en and mem_we are 0. resp_data, mem_addr, mem_byteen and mem_wdata are 0.
- Accept: on req_valid&&req_ready, register we, funct3 and wdata, plus eff=req_base+req_imm mod 2^32.
- Address: mem_addr=eff[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap.
- Fault check at accept:
  - misaligned: half with eff[0]=1; word with eff[1:0]!=0.
  - illegal funct3: load funct3 not in {000,001,010,100,101}; store funct3 not in {000,001,010}.
  - On a fault, go to RESP directly with no RAM access (mem_en stays 0).
- State IDLE: req_ready=1. Accept leads to ISSUE, or to RESP on a fault.
- State ISSUE (1 cycle):
  - mem_en=1, mem_we=stored we; mem_addr/byteen/wdata are stable from registers.
  - A store goes to RESP.
  - A load goes to WAIT with cnt=1.
- State WAIT:
  - If cnt==RD_LAT: capture the extracted mem_rdata into resp_data and go to RESP.
  - Otherwise cnt++.
  - mem_en=0 throughout WAIT.
- State RESP: resp_valid=1 for exactly one cycle, resp_fault as computed, then IDLE.
- resp_data holds its value until the next capture; it is cleared to 0 on store/fault responses.
- Latency from accept cycle to resp_valid:
  - load: RD_LAT+2 cycles
  - store: 2 cycles
  - fault: 1 cycle
- Throughput: one op in flight; a new accept is possible in the cycle after RESP.
- Byte enables, with o=eff[1:0]:
  - byte: 4'b0001<<o
  - half: 4'b0011<<(2*eff[1])
  - word: 4'b1111
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as-is.
- Load extract: select byte o or half eff[1], then:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- req_valid is ignored outside IDLE; request inputs need not be held after accept.
- Reset mid-operation: an immediate return to IDLE with all outputs at reset values. An in-flight RAM access is abandoned and no response is produced.

Decomposition:
- lsu_pkg holds:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101)
  - state enum lsu_state_t {IDLE, ISSUE, WAIT, RESP}
  - the byte-enable width constant BE_W=4
- One combinational sub-module, lsu_align, contains byte-lane steering:
  - store: funct3 and offset give byteen and wdata.
  - load: funct3, offset and rdata give the extended result.
- The FSM, counter and registers stay in lsu.

Test Plan:
- Reset released, then SW base=0x100 imm=0x4 wdata=0xDEADBEEF -> ISSUE cycle shows mem_addr=0x41, byteen=1111, we=1; resp_valid 2 cycles after accept, fault=0.
- SB base=0x103 imm=0 wdata=0x000000A5 -> byteen=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x40.
- LB at 0x101 with mem_rdata=0x1234_80FF -> resp_data=0xFFFFFF80; LBU at the same address -> 0x00000080; resp_valid exactly RD_LAT+2 cycles after accept (check with RD_LAT=1 and 3).
- LH at 0x102 with mem_rdata=0x8001_0000 -> resp_data=0xFFFF8001; LW at 0x0 returns mem_rdata unchanged.
- LW at 0x102, SH at 0x001, and load funct3=011 -> resp_fault=1 and resp_data=0 one cycle after accept; mem_en never asserted.
- Assert rst_n low during WAIT -> outputs immediately at reset values, req_ready=1, and no resp_valid after release; then base=0xFFFFFFFC imm=0x8 gives eff=0x4 and mem_addr=0x1 (wrap).
